pipelined_tree_compare_solver: RTL

- Pipelined, backpressured successor to the combinational tree compare solver.
- Finds the minimum among the valid channel values and a default value.
- Also reports which channel won, so downstream logic can act on it.
- Sits between per-channel producers and a consumer that may stall. Pipelining cuts the long compare path for large CHANNEL_COUNT.

---
 rtl/pipelined_tree_compare_solver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_tree_compare_solver.sv
// pipelined_tree_compare_solver
//   Finds the minimum among the qualified channel values and a default value,
//   and reports which entry won. Entries are channels 0..CHANNEL_COUNT-1 plus
//   the default, which is entry CHANNEL_COUNT and is always valid. The entries
//   are reduced by a binary tree of compare nodes. A register stage follows
//   every REG_INTERVAL tree levels and always follows the last level. One
//   global stall signal freezes the whole pipeline, so bubbles are never
//   collapsed.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   default_value       fallback value (entry CHANNEL_COUNT)
//   values, valids      channel i occupies values[i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid/in_ready   input handshake; in_ready is the global advance
//   result              minimum value
//   result_index        winning entry (CHANNEL_COUNT means the default won)
//   result_from_channel 1 when a channel, not the default, won
//   out_valid/out_ready output handshake

// One 2-input compare node. Entry a always carries lower original indices
// than entry b, so a wins on ties. An invalid entry always loses.
module ptcs_node #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]  a_val,
  input  logic [INDEX_WIDTH-1:0] a_idx,
  input  logic                   a_ok,
  input  logic [DATA_WIDTH-1:0]  b_val,
  input  logic [INDEX_WIDTH-1:0] b_idx,
  input  logic                   b_ok,
  output logic [DATA_WIDTH-1:0]  y_val,
  output logic [INDEX_WIDTH-1:0] y_idx,
  output logic                   y_ok
);
  logic take_b;
  assign take_b = b_ok && (!a_ok || (b_val < a_val));
  assign y_val  = take_b ? b_val : a_val;
  assign y_idx  = take_b ? b_idx : a_idx;
  assign y_ok   = a_ok || b_ok;
endmodule

module pipelined_tree_compare_solver #(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_COUNT = 5,
  parameter int REG_INTERVAL  = 1,
  parameter int INDEX_WIDTH   = $clog2(CHANNEL_COUNT + 1)
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [DATA_WIDTH-1:0]               default_value,
  input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values,
  input  logic [CHANNEL_COUNT-1:0]            valids,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [DATA_WIDTH-1:0]               result,
  output logic [INDEX_WIDTH-1:0]              result_index,
  output logic                                result_from_channel,
  output logic                                out_valid,
  input  logic                                out_ready
);
  localparam int N      = CHANNEL_COUNT + 1;
  localparam int LEVELS = ($clog2(N) < 1) ? 1 : $clog2(N);
  localparam int L      = (LEVELS + REG_INTERVAL - 1) / REG_INTERVAL;

  // Number of entries entering tree level l.
  function automatic int cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  // Whether a register stage follows tree level l.
  function automatic bit is_reg(input int l);
    return (((l + 1) % REG_INTERVAL) == 0) || (l == LEVELS - 1);
  endfunction

  logic         advance;
  logic         accept;
  logic [L:1]   vld_pipe;

  // Global stall: everything moves together or nothing moves.
  assign advance   = !vld_pipe[L] || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign out_valid = vld_pipe[L];

  // Valid shift register; the cast drops the bit shifted out of the top.
  always_ff @(posedge clk) begin
    if (!reset_n)     vld_pipe <= '0;
    else if (advance) vld_pipe <= L'({vld_pipe, accept});
  end

  for (genvar l = 0; l < LEVELS; l++) begin : lv
    localparam int NI = cnt(l);
    localparam int NO = cnt(l + 1);

    logic [NI-1:0][DATA_WIDTH-1:0]  in_val;
    logic [NI-1:0][INDEX_WIDTH-1:0] in_idx;
    logic [NI-1:0]                  in_ok;
    logic [NO-1:0][DATA_WIDTH-1:0]  d_val;
    logic [NO-1:0][INDEX_WIDTH-1:0] d_idx;
    logic [NO-1:0]                  d_ok;
    logic [NO-1:0][DATA_WIDTH-1:0]  q_val;
    logic [NO-1:0][INDEX_WIDTH-1:0] q_idx;
    logic [NO-1:0]                  q_ok;

    if (l == 0) begin : src
      for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : ch
        assign in_val[i] = values[i*DATA_WIDTH +: DATA_WIDTH];
        assign in_idx[i] = INDEX_WIDTH'(i);
        assign in_ok[i]  = valids[i];
      end
      assign in_val[CHANNEL_COUNT] = default_value;
      assign in_idx[CHANNEL_COUNT] = INDEX_WIDTH'(CHANNEL_COUNT);
      assign in_ok[CHANNEL_COUNT]  = 1'b1;
    end else begin : link
      assign in_val = lv[l-1].q_val;
      assign in_idx = lv[l-1].q_idx;
      assign in_ok  = lv[l-1].q_ok;
    end

    for (genvar j = 0; j < NO; j++) begin : nd
      if (2*j + 1 < NI) begin : cmp
        ptcs_node #(
          .DATA_WIDTH (DATA_WIDTH),
          .INDEX_WIDTH(INDEX_WIDTH)
        ) u_node (
          .a_val(in_val[2*j]),   .a_idx(in_idx[2*j]),   .a_ok(in_ok[2*j]),
          .b_val(in_val[2*j+1]), .b_idx(in_idx[2*j+1]), .b_ok(in_ok[2*j+1]),
          .y_val(d_val[j]),      .y_idx(d_idx[j]),      .y_ok(d_ok[j])
        );
      end else begin : pass
        // Odd entry out: rides through this level untouched.
        assign d_val[j] = in_val[2*j];
        assign d_idx[j] = in_idx[2*j];
        assign d_ok[j]  = in_ok[2*j];
      end
    end

    if (is_reg(l)) begin : pr
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          q_val <= '0;
          q_idx <= '0;
          q_ok  <= '0;
        end else if (advance) begin
          q_val <= d_val;
          q_idx <= d_idx;
          q_ok  <= d_ok;
        end
      end
    end else begin : thru
      assign q_val = d_val;
      assign q_idx = d_idx;
      assign q_ok  = d_ok;
    end
  end

  assign result       = lv[LEVELS-1].q_val[0];
  assign result_index = lv[LEVELS-1].q_idx[0];
  // Gated by out_valid so the reset state reads 0 even though index 0 is a channel.
  assign result_from_channel = out_valid && lv[LEVELS-1].q_ok[0] &&
                               (result_index != INDEX_WIDTH'(CHANNEL_COUNT));
endmodule
